// File: rtl/fpu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mul_seq
// Description : Sequential IEEE-754-format floating-point multiplier. Each
//               request is handled by a shift-and-add significand multiply
//               that takes one add step and one shift step per significand
//               bit, then normalise, round, range check and pack.
//               Zero, infinity and NaN operands skip the multiply loop.
//               Denormal inputs are flushed to signed zero, and the unit
//               never produces denormal outputs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : EXP_W        exponent field width (default 8)
//               MAN_W        stored fraction width (default 23)
//               Word width W = 1 + EXP_W + MAN_W
// Ports       : clk          single clock, rising edge
//               arst_n       asynchronous active-low reset
//               start        request, sampled only while idle
//               a_operand    multiplicand, W bits
//               b_operand    multiplier, W bits
//               ack          consumer accepts the presented result
//               busy         high whenever the unit is not idle
//               result_valid result and flags are valid
//               result       packed product, W bits
//               flag_ovf     overflow, result is signed infinity
//               flag_unf     underflow, result is signed zero
//               flag_inv     invalid operation, result is canonical qNaN
// Build macro : FPU_MUL_RNE_EN  defined   -> round to nearest, ties to even
//                               undefined -> truncate toward zero
// ============================================================================
module fpu_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    input  logic [EXP_W+MAN_W:0]   b_operand,
    input  logic                   ack,
    output logic                   busy,
    output logic                   result_valid,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_inv
);

    localparam int c_w     = 1 + EXP_W + MAN_W;
    localparam int c_sig_w = MAN_W + 1;
    localparam int c_cnt_w = $clog2(c_sig_w + 1);
    // Two guard bits above the exponent field hold the sign and the carry
    // of the raw exponent sum.
    localparam int c_ew    = EXP_W + 2;

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_sig_w);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ew-1:0]    c_bias     = c_ew'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0]   c_exp_ones = {EXP_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_START         = 3'd1,
        ST_PRODUCT_ADD   = 3'd2,
        ST_PRODUCT_SHIFT = 3'd3,
        ST_RESULT_SET    = 3'd4,
        ST_RESULT_VALID  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [c_w-1:0]       r_a;
    logic [c_w-1:0]       r_b;
    logic [c_sig_w-1:0]   r_mcand;
    logic [c_sig_w-1:0]   r_acc;
    logic [c_sig_w-1:0]   r_mplier;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_ew-1:0]      r_exp;
    logic                 r_sign;
    logic                 r_special;
    logic [c_w-1:0]       r_spec_word;
    logic                 r_spec_inv;

    // ------------------------------------------------------------------
    // Operand unpack and special-case classification
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]     w_exp_a;
    logic [EXP_W-1:0]     w_exp_b;
    logic [MAN_W-1:0]     w_frac_a;
    logic [MAN_W-1:0]     w_frac_b;
    logic                 w_sign;
    logic                 w_zero_a;
    logic                 w_zero_b;
    logic                 w_inf_a;
    logic                 w_inf_b;
    logic                 w_nan_a;
    logic                 w_nan_b;
    logic                 w_special;
    logic                 w_spec_inv;
    logic [c_w-1:0]       w_spec_word;

    always_comb begin
        w_exp_a  = r_a[c_w-2 -: EXP_W];
        w_exp_b  = r_b[c_w-2 -: EXP_W];
        w_frac_a = r_a[MAN_W-1:0];
        w_frac_b = r_b[MAN_W-1:0];
        w_sign   = r_a[c_w-1] ^ r_b[c_w-1];

        // A zero exponent field covers both true zero and denormals,
        // which are flushed to zero.
        w_zero_a = (w_exp_a == '0);
        w_zero_b = (w_exp_b == '0);
        w_inf_a  = (w_exp_a == c_exp_ones) && (w_frac_a == '0);
        w_inf_b  = (w_exp_b == c_exp_ones) && (w_frac_b == '0);
        w_nan_a  = (w_exp_a == c_exp_ones) && (w_frac_a != '0);
        w_nan_b  = (w_exp_b == c_exp_ones) && (w_frac_b != '0);

        w_special  = w_nan_a | w_nan_b | w_inf_a | w_inf_b | w_zero_a | w_zero_b;
        w_spec_inv = w_nan_a | w_nan_b | (w_zero_a & w_inf_b) | (w_inf_a & w_zero_b);

        if (w_spec_inv) begin
            w_spec_word = {1'b0, c_exp_ones, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_inf_a | w_inf_b) begin
            w_spec_word = {w_sign, c_exp_ones, {MAN_W{1'b0}}};
        end else begin
            w_spec_word = {w_sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Normalise, round and range check of the finished product.
    // The product is {r_acc, r_mplier}, with the binary point two bits
    // below its MSB, so it lies in [1, 4).
    // ------------------------------------------------------------------
    logic                 w_norm;
    logic [c_sig_w-1:0]   w_mant_pre;
    logic                 w_round_up;
    logic [c_sig_w:0]     w_mant_rnd;
    logic                 w_rcarry;
    logic [MAN_W-1:0]     w_frac;
    logic [c_ew-1:0]      w_exp_fin;
    logic                 w_ovf;
    logic                 w_unf;

`ifdef FPU_MUL_RNE_EN
    logic                 w_guard;
    logic                 w_sticky;

    always_comb begin
        w_guard    = w_norm ? r_mplier[c_sig_w-1] : r_mplier[c_sig_w-2];
        w_sticky   = w_norm ? (|r_mplier[c_sig_w-2:0]) : (|r_mplier[c_sig_w-3:0]);
        // Round up above the halfway point, or exactly at it when the kept
        // LSB is odd.
        w_round_up = w_guard & (w_sticky | w_mant_pre[0]);
    end
`else
    always_comb begin
        w_round_up = 1'b0;
    end
`endif

    always_comb begin
        w_norm     = r_acc[c_sig_w-1];
        w_mant_pre = w_norm ? r_acc : {r_acc[c_sig_w-2:0], r_mplier[c_sig_w-1]};
        w_mant_rnd = {1'b0, w_mant_pre} + {{c_sig_w{1'b0}}, w_round_up};
        // A rounding carry leaves the significand at exactly 2.0, so the
        // renormalised fraction is taken one bit higher.
        w_rcarry   = w_mant_rnd[c_sig_w];
        w_frac     = w_rcarry ? w_mant_rnd[c_sig_w-1:1] : w_mant_rnd[MAN_W-1:0];
        w_exp_fin  = r_exp + {{(c_ew-1){1'b0}}, w_norm} + {{(c_ew-1){1'b0}}, w_rcarry};
        w_ovf      = !w_exp_fin[c_ew-1] && (w_exp_fin[c_ew-2:0] >= {1'b0, c_exp_ones});
        w_unf      = w_exp_fin[c_ew-1] || (w_exp_fin == '0);
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:          if (start) w_next = ST_START;
            ST_START:         w_next = w_special ? ST_RESULT_SET : ST_PRODUCT_ADD;
            ST_PRODUCT_ADD:   w_next = ST_PRODUCT_SHIFT;
            ST_PRODUCT_SHIFT: w_next = (r_cnt == c_cnt_one) ? ST_RESULT_SET : ST_PRODUCT_ADD;
            ST_RESULT_SET:    w_next = ST_RESULT_VALID;
            ST_RESULT_VALID:  if (ack) w_next = ST_IDLE;
            default:          w_next = ST_IDLE;
        endcase
    end

    assign busy         = (r_state != ST_IDLE);
    assign result_valid = (r_state == ST_RESULT_VALID);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_special   <= 1'b0;
            r_spec_word <= '0;
            r_spec_inv  <= 1'b0;
            result      <= '0;
            flag_ovf    <= 1'b0;
            flag_unf    <= 1'b0;
            flag_inv    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a_operand;
                        r_b      <= b_operand;
                        flag_ovf <= 1'b0;
                        flag_unf <= 1'b0;
                        flag_inv <= 1'b0;
                    end
                end
                ST_START: begin
                    r_mcand     <= {1'b1, w_frac_a};
                    r_mplier    <= {1'b1, w_frac_b};
                    r_acc       <= '0;
                    r_carry     <= 1'b0;
                    r_cnt       <= c_cnt_load;
                    r_exp       <= {2'b00, w_exp_a} + {2'b00, w_exp_b} - c_bias;
                    r_sign      <= w_sign;
                    r_special   <= w_special;
                    r_spec_word <= w_spec_word;
                    r_spec_inv  <= w_spec_inv;
                end
                ST_PRODUCT_ADD: begin
                    if (r_mplier[0]) begin
                        {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, r_mcand};
                    end
                end
                ST_PRODUCT_SHIFT: begin
                    // Product bits retire into the vacated multiplier bits.
                    {r_carry, r_acc, r_mplier} <= {1'b0, r_carry, r_acc, r_mplier[c_sig_w-1:1]};
                    r_cnt <= r_cnt - c_cnt_one;
                end
                ST_RESULT_SET: begin
                    if (r_special) begin
                        result   <= r_spec_word;
                        flag_inv <= r_spec_inv;
                    end else if (w_ovf) begin
                        result   <= {r_sign, c_exp_ones, {MAN_W{1'b0}}};
                        flag_ovf <= 1'b1;
                    end else if (w_unf) begin
                        result   <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
                        flag_unf <= 1'b1;
                    end else begin
                        result   <= {r_sign, w_exp_fin[EXP_W-1:0], w_frac};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
